// File: rtl/memory_pkg.sv
// ============================================================================
// memory_pkg
// Shared types and defaults for the L2C line-refill path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_pkg;

  localparam int unsigned c_line_addr_w              = 58;
  localparam int unsigned c_beat_w                   = 64;
  localparam int unsigned c_req_depth_default        = 4;
  localparam int unsigned c_beats_per_line_default   = 8;

  typedef logic [c_line_addr_w-1:0]                             line_addr_t;
  typedef logic [c_beat_w*c_beats_per_line_default-1:0]         refill_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    COLLECT = 2'd2,
    RESP    = 2'd3
  } refill_state_e;

endpackage

`default_nettype wire

// File: rtl/line_req_fifo.sv
// ============================================================================
// line_req_fifo
// Circular request FIFO with full/empty/count; flush clears and beats a push.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 58
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_cnt_w'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2c_line_refill_responder.sv
// ============================================================================
// l2c_line_refill_responder
// Queues L1 line-miss requests, reads each line as beats, returns whole lines.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l2c_line_refill_responder
  import memory_pkg::*;
#(
  parameter int unsigned REQ_DEPTH      = c_req_depth_default,
  parameter int unsigned LINE_ADDR_W    = c_line_addr_w,
  parameter int unsigned BEAT_W         = c_beat_w,
  parameter int unsigned BEATS_PER_LINE = c_beats_per_line_default
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              l1_req_valid_i,
  output logic                              l1_req_ready_o,
  input  logic [LINE_ADDR_W-1:0]            l1_req_line_addr_i,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [LINE_ADDR_W-1:0]            mem_req_line_addr_o,
  input  logic                              mem_beat_valid_i,
  input  logic [BEAT_W-1:0]                 mem_beat_data_i,
  output logic                              l1_rsp_valid_o,
  input  logic                              l1_rsp_ready_i,
  output logic [LINE_ADDR_W-1:0]            l1_rsp_line_addr_o,
  output logic [BEAT_W*BEATS_PER_LINE-1:0]  l1_rsp_line_o,
  output logic [$clog2(REQ_DEPTH+1)-1:0]    pending_o
);

  localparam int unsigned c_line_w     = BEAT_W * BEATS_PER_LINE;
  localparam int unsigned c_beat_cnt_w = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int unsigned c_cnt_w      = $clog2(REQ_DEPTH+1);

  refill_state_e             r_state;
  refill_state_e             w_state_next;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [c_cnt_w-1:0]        w_fifo_count;
  logic [LINE_ADDR_W-1:0]    w_fifo_head;
  logic                      w_push;
  logic                      w_start;
  logic                      w_last_beat;
  logic [LINE_ADDR_W-1:0]    r_cur_addr;
  logic [c_line_w-1:0]       r_line;
  logic [c_beat_cnt_w-1:0]   r_beat_cnt;

  // Ready depends only on queue occupancy, so it never sees l1_rsp_ready_i.
  assign l1_req_ready_o = !w_fifo_full && !rst_i;
  assign w_push         = l1_req_valid_i && l1_req_ready_o;
  assign w_last_beat    = (r_beat_cnt == c_beat_cnt_w'(BEATS_PER_LINE - 1));

  line_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (LINE_ADDR_W)
  ) u_req_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_data  (l1_req_line_addr_i),
    .i_pop   (w_start),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_start         = 1'b0;
    mem_req_valid_o = 1'b0;
    l1_rsp_valid_o  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A flushing cycle drops the head rather than issuing it.
        if (!w_fifo_empty && !flush_i) begin
          w_start      = 1'b1;
          w_state_next = MEM_REQ;
        end
      end
      MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_state_next = COLLECT;
      end
      COLLECT: begin
        if (mem_beat_valid_i && w_last_beat) w_state_next = RESP;
      end
      RESP: begin
        l1_rsp_valid_o = 1'b1;
        if (l1_rsp_ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur_addr <= '0;
      r_line     <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_start) r_cur_addr <= w_fifo_head;
      if (r_state == MEM_REQ && mem_req_ready_i) r_beat_cnt <= '0;
      if (r_state == COLLECT && mem_beat_valid_i) begin
        r_line[32'(r_beat_cnt) * BEAT_W +: BEAT_W] <= mem_beat_data_i;
        r_beat_cnt <= r_beat_cnt + c_beat_cnt_w'(1);
      end
    end
  end

  assign mem_req_line_addr_o = r_cur_addr;
  assign l1_rsp_line_addr_o  = r_cur_addr;
  assign l1_rsp_line_o       = r_line;
  assign pending_o           = w_fifo_count + c_cnt_w'(r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_l2c_line_refill_responder.sv
// ============================================================================
// tb_l2c_line_refill_responder
// Directed scenario bench for the L2C line-refill responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_l2c_line_refill_responder;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         l1_req_valid_i = 1'b0;
  logic         l1_req_ready_o;
  logic [57:0]  l1_req_line_addr_i = '0;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic [57:0]  mem_req_line_addr_o;
  logic         mem_beat_valid_i = 1'b0;
  logic [63:0]  mem_beat_data_i = '0;
  logic         l1_rsp_valid_o;
  logic         l1_rsp_ready_i = 1'b0;
  logic [57:0]  l1_rsp_line_addr_o;
  logic [511:0] l1_rsp_line_o;
  logic [2:0]   pending_o;

  int n_vec = 0;
  int n_err = 0;

  l2c_line_refill_responder dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .l1_req_valid_i      (l1_req_valid_i),
    .l1_req_ready_o      (l1_req_ready_o),
    .l1_req_line_addr_i  (l1_req_line_addr_i),
    .mem_req_valid_o     (mem_req_valid_o),
    .mem_req_ready_i     (mem_req_ready_i),
    .mem_req_line_addr_o (mem_req_line_addr_o),
    .mem_beat_valid_i    (mem_beat_valid_i),
    .mem_beat_data_i     (mem_beat_data_i),
    .l1_rsp_valid_o      (l1_rsp_valid_o),
    .l1_rsp_ready_i      (l1_rsp_ready_i),
    .l1_rsp_line_addr_o  (l1_rsp_line_addr_o),
    .l1_rsp_line_o       (l1_rsp_line_o),
    .pending_o           (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [511:0] exp_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic push(input logic [57:0] addr);
    l1_req_valid_i = 1'b1; l1_req_line_addr_i = addr;
    step();
    l1_req_valid_i = 1'b0;
  endtask

  task automatic accept_mem_req();
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int gap, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      repeat ($urandom_range(0, gap)) step();
      mem_beat_valid_i = 1'b1; mem_beat_data_i = base + 64'(k);
      step();
      mem_beat_valid_i = 1'b0; mem_beat_data_i = 64'hDEAD_BEEF_0000_0000;
    end
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid_o) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    n_vec++; if (l1_req_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", l1_req_ready_o); end
    n_vec++; if (mem_req_valid_o !== 1'b0 || l1_rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valids: got mem=%b rsp=%b want 0", mem_req_valid_o, l1_rsp_valid_o); end
    n_vec++; if (pending_o !== 3'd0 || l1_rsp_line_o !== '0) begin n_err++; $display("FAIL reset_state: got pending=%0d line=%h want 0", pending_o, l1_rsp_line_o); end
    step(); rst_i = 1'b0; #1;
    n_vec++; if (l1_req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", l1_req_ready_o); end
  endtask

  task automatic test_single();
    mem_req_ready_i = 1'b1;
    push(58'h12);
    n_vec++; if (mem_req_valid_o !== 1'b0 || pending_o !== 3'd1) begin n_err++; $display("FAIL single_push: got mem_valid=%b pending=%0d want 0/1", mem_req_valid_o, pending_o); end
    step();
    n_vec++; if (mem_req_valid_o !== 1'b1 || mem_req_line_addr_o !== 58'h12) begin n_err++; $display("FAIL single_mem_req: got valid=%b addr=%h want 1/12", mem_req_valid_o, mem_req_line_addr_o); end
    step();
    mem_req_ready_i = 1'b0;
    send_beats(64'h0, 0, 0, 6);
    n_vec++; if (l1_rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_early_rsp: got %b want 0", l1_rsp_valid_o); end
    send_beats(64'h0, 0, 7, 7);
    n_vec++; if (l1_rsp_valid_o !== 1'b1 || l1_rsp_line_addr_o !== 58'h12) begin n_err++; $display("FAIL single_rsp: got valid=%b addr=%h want 1/12", l1_rsp_valid_o, l1_rsp_line_addr_o); end
    n_vec++; if (l1_rsp_line_o !== exp_line(64'h0)) begin n_err++; $display("FAIL single_line: got %h want %h", l1_rsp_line_o, exp_line(64'h0)); end
    n_vec++; if (pending_o !== 3'd1) begin n_err++; $display("FAIL single_pending_rsp: got %0d want 1", pending_o); end
    l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
    n_vec++; if (pending_o !== 3'd0 || l1_rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_done: got pending=%0d valid=%b want 0/0", pending_o, l1_rsp_valid_o); end
  endtask

  task automatic test_queue_full();
    bit ok;
    l1_req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin l1_req_line_addr_i = 58'h21 + 58'(i); step(); end
    n_vec++; if (l1_req_ready_o !== 1'b0 || pending_o !== 3'd5) begin n_err++; $display("FAIL full_state: got ready=%b pending=%0d want 0/5", l1_req_ready_o, pending_o); end
    l1_req_line_addr_i = 58'h66; step(); l1_req_valid_i = 1'b0;
    n_vec++; if (pending_o !== 3'd5) begin n_err++; $display("FAIL full_refuse: got pending=%0d want 5", pending_o); end
    for (int i = 0; i < 5; i++) begin
      wait_mem_req(ok);
      n_vec++; if (!ok || mem_req_line_addr_o !== 58'h21 + 58'(i)) begin n_err++; $display("FAIL full_order%0d: got ok=%b addr=%h want %h", i, ok, mem_req_line_addr_o, 58'h21 + 58'(i)); end
      accept_mem_req();
      send_beats(64'(i) << 8, 0, 0, 7);
      n_vec++; if (l1_rsp_valid_o !== 1'b1 || l1_rsp_line_o !== exp_line(64'(i) << 8)) begin n_err++; $display("FAIL full_line%0d: got valid=%b line=%h", i, l1_rsp_valid_o, l1_rsp_line_o); end
      l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
    end
    step(); step();
    n_vec++; if (pending_o !== 3'd0 || mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL full_drained: got pending=%0d mem_valid=%b want 0/0", pending_o, mem_req_valid_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    push(58'h31); push(58'h32);
    wait_mem_req(ok);
    accept_mem_req();
    send_beats(64'h3100, 1, 0, 7);
    for (int i = 0; i < 10; i++) begin
      step();
      if (l1_rsp_valid_o !== 1'b1 || l1_rsp_line_addr_o !== 58'h31 || l1_rsp_line_o !== exp_line(64'h3100) || mem_req_valid_o !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    n_vec++; if (pending_o !== 3'd2) begin n_err++; $display("FAIL bp_pending: got %0d want 2", pending_o); end
    l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
    n_vec++; if (l1_rsp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_idle: got rsp=%b mem=%b want 0/0", l1_rsp_valid_o, mem_req_valid_o); end
    step();
    n_vec++; if (mem_req_valid_o !== 1'b1 || mem_req_line_addr_o !== 58'h32) begin n_err++; $display("FAIL bp_next: got valid=%b addr=%h want 1/32", mem_req_valid_o, mem_req_line_addr_o); end
    accept_mem_req();
    send_beats(64'h3200, 0, 0, 7);
    l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
  endtask

  task automatic test_gapped_order();
    bit ok;
    logic [57:0] addrs [3] = '{58'hA, 58'hB, 58'hC};
    mem_beat_valid_i = 1'b1; mem_beat_data_i = 64'hBAD0;
    step(); step();
    mem_beat_valid_i = 1'b0;
    push(addrs[0]); push(addrs[1]); push(addrs[2]);
    for (int i = 0; i < 3; i++) begin
      wait_mem_req(ok);
      // Junk beats while waiting in MEM_REQ must not land in the line.
      mem_beat_valid_i = 1'b1; mem_beat_data_i = 64'hBAD1;
      step(); step();
      mem_beat_valid_i = 1'b0;
      n_vec++; if (!ok || mem_req_line_addr_o !== addrs[i]) begin n_err++; $display("FAIL gap_req%0d: got ok=%b addr=%h want %h", i, ok, mem_req_line_addr_o, addrs[i]); end
      accept_mem_req();
      send_beats(64'(i + 10) << 12, 2, 0, 7);
      n_vec++; if (l1_rsp_valid_o !== 1'b1 || l1_rsp_line_addr_o !== addrs[i]) begin n_err++; $display("FAIL gap_rsp_addr%0d: got valid=%b addr=%h want %h", i, l1_rsp_valid_o, l1_rsp_line_addr_o, addrs[i]); end
      n_vec++; if (l1_rsp_line_o !== exp_line(64'(i + 10) << 12)) begin n_err++; $display("FAIL gap_line%0d: got %h want %h", i, l1_rsp_line_o, exp_line(64'(i + 10) << 12)); end
      l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
    end
  endtask

  task automatic test_flush();
    bit ok;
    int seen = 0;
    push(58'h41); push(58'h42); push(58'h43); push(58'h44);
    wait_mem_req(ok);
    accept_mem_req();
    send_beats(64'h4100, 0, 0, 1);
    n_vec++; if (pending_o !== 3'd4) begin n_err++; $display("FAIL flush_pre: got pending=%0d want 4", pending_o); end
    flush_i = 1'b1; l1_req_valid_i = 1'b1; l1_req_line_addr_i = 58'h4F;
    step();
    flush_i = 1'b0; l1_req_valid_i = 1'b0;
    n_vec++; if (pending_o !== 3'd1) begin n_err++; $display("FAIL flush_pending: got %0d want 1", pending_o); end
    send_beats(64'h4100, 1, 2, 7);
    n_vec++; if (l1_rsp_valid_o !== 1'b1 || l1_rsp_line_addr_o !== 58'h41 || l1_rsp_line_o !== exp_line(64'h4100)) begin n_err++; $display("FAIL flush_line: got valid=%b addr=%h line=%h", l1_rsp_valid_o, l1_rsp_line_addr_o, l1_rsp_line_o); end
    l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin if (mem_req_valid_o) seen++; step(); end
    n_vec++; if (pending_o !== 3'd0 || seen != 0) begin n_err++; $display("FAIL flush_after: got pending=%0d mem_reqs=%0d want 0/0", pending_o, seen); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push(58'h51);
    wait_mem_req(ok);
    accept_mem_req();
    send_beats(64'h5100, 0, 0, 2);
    #2 rst_i = 1'b1; #1;
    n_vec++; if (pending_o !== 3'd0 || mem_req_line_addr_o !== '0 || l1_rsp_line_o !== '0 || l1_req_ready_o !== 1'b0 || l1_rsp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_outputs: got pending=%0d addr=%h ready=%b line=%h want all 0", pending_o, mem_req_line_addr_o, l1_req_ready_o, l1_rsp_line_o);
    end
    step(); rst_i = 1'b0;
    mem_beat_valid_i = 1'b1; mem_beat_data_i = 64'hBAD2;
    step(); step();
    mem_beat_valid_i = 1'b0;
    n_vec++; if (pending_o !== 3'd0 || l1_req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_idle: got pending=%0d ready=%b want 0/1", pending_o, l1_req_ready_o); end
    push(58'h52);
    wait_mem_req(ok);
    n_vec++; if (!ok || mem_req_line_addr_o !== 58'h52) begin n_err++; $display("FAIL rst_mid_req: got ok=%b addr=%h want 52", ok, mem_req_line_addr_o); end
    accept_mem_req();
    send_beats(64'h5200, 0, 0, 7);
    n_vec++; if (l1_rsp_valid_o !== 1'b1 || l1_rsp_line_o !== exp_line(64'h5200)) begin n_err++; $display("FAIL rst_mid_line: got valid=%b line=%h want %h", l1_rsp_valid_o, l1_rsp_line_o, exp_line(64'h5200)); end
    l1_rsp_ready_i = 1'b1; step(); l1_rsp_ready_i = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_queue_full();
    test_backpressure();
    test_gapped_order();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
